// File: rtl/exotiny_console_mon.sv
// rtl/exotiny_console_mon.sv - console byte capture FIFO with pass/fail signature match and watchdog
// Optional simulation console output when EXOTINY_CONSOLE_PRINT_EN is defined.
module exotiny_console_mon #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] PASS_PAT = "DONE",
    parameter int unsigned PASS_LEN = 4,
    parameter logic [31:0] FAIL_PAT = "ERR",
    parameter int unsigned FAIL_LEN = 3,
    parameter int unsigned TIMEOUT  = 600000,
    parameter int unsigned TO_W     = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       sel_i,
    input  logic                       stb_i,
    input  logic [7:0]                 wdat_i,
    input  logic                       rd_rdy_i,
    output logic                       rd_vld_o,
    output logic [7:0]                 rd_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o,
    output logic                       overflow_o,
    output logic                       pass_o,
    output logic                       fail_o,
    output logic                       timeout_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    localparam logic [31:0] PASS_MASK = (PASS_LEN >= 4) ? 32'hFFFF_FFFF
                                                        : ((32'd1 << (8*PASS_LEN)) - 32'd1);
    localparam logic [31:0] FAIL_MASK = (FAIL_LEN >= 4) ? 32'hFFFF_FFFF
                                                        : ((32'd1 << (8*FAIL_LEN)) - 32'd1);

    logic          stb_q, stb_d;
    logic [31:0]   sh_q, sh_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          to_q, to_d;
    logic [7:0]    mem_q [DEPTH];

    logic cap, full, empty, pop, push, pass_m, fail_m;

    // Capture only on the strobe's rising edge, and only if the console was already selected.
    assign cap   = sel_i & stb_i & ~stb_q;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign pop   = ~empty & rd_rdy_i;
    assign push  = cap & (~full | pop);

    assign pass_m = ((sh_q & PASS_MASK) == (PASS_PAT & PASS_MASK));
    assign fail_m = ((sh_q & FAIL_MASK) == (FAIL_PAT & FAIL_MASK));

    always_comb begin
        stb_d    = stb_i;
        sh_d     = cap ? {sh_q[23:0], wdat_i} : sh_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
        ovf_d  = ovf_q | (cap & full & ~pop);
        // First terminal flag wins; fail beats pass when both match together.
        fail_d = fail_q | (fail_m & ~pass_q);
        pass_d = pass_q | (pass_m & ~fail_m & ~fail_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stb_q    <= 1'b0;
            sh_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            stb_q    <= stb_d;
            sh_q     <= sh_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdat_i;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wd
            logic [TO_W-1:0] wd_q, wd_d;
            logic            running;

            assign running = ~pass_q & ~fail_q & ~to_q;

            always_comb begin
                wd_d = wd_q;
                to_d = to_q;
                if (running) begin
                    if (wd_q == TO_W'(TIMEOUT - 1)) begin
                        to_d = 1'b1;
                    end else begin
                        wd_d = wd_q + TO_W'(1);
                    end
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    wd_q <= '0;
                    to_q <= 1'b0;
                end else begin
                    wd_q <= wd_d;
                    to_q <= to_d;
                end
            end
        end else begin : g_no_wd
            assign to_d = 1'b0;
            assign to_q = 1'b0;
        end
    endgenerate

`ifdef EXOTINY_CONSOLE_PRINT_EN
    always @(posedge clk_i) begin
        if (!rst_i) begin
            if (cap) begin
                $write("%c", wdat_i);
            end
            if (pass_d && !pass_q) begin
                $display("PASS");
                $finish;
            end
            if (fail_d && !fail_q) begin
                $display("FAIL");
                $fatal;
            end
            if (to_d && !to_q) begin
                $display("TIMEOUT");
                $fatal;
            end
        end
    end
`else
    // Flags only; the consumer reads status and drains bytes itself.
`endif

    assign rd_vld_o   = ~empty;
    assign rd_dat_o   = mem_q[rd_ptr_q];
    assign cnt_o      = cnt_q;
    assign overflow_o = ovf_q;
    assign pass_o     = pass_q;
    assign fail_o     = fail_q;
    assign timeout_o  = to_q;

endmodule

// File: tb/tb_exotiny_console_mon.sv
// tb/tb_exotiny_console_mon.sv - directed self-checking bench for exotiny_console_mon
module tb_exotiny_console_mon;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       stb = 1'b0;
    logic [7:0] wdat = 8'h00;
    logic       rd_rdy = 1'b0;
    logic       rd_vld;
    logic [7:0] rd_dat;
    logic [4:0] cnt;
    logic       ovf, pass, fail, tmo;

    int passed = 0;
    int total  = 0;

    exotiny_console_mon #(
        .DEPTH   (16),
        .PASS_PAT("DONE"),
        .PASS_LEN(4),
        .FAIL_PAT("ERR"),
        .FAIL_LEN(3),
        .TIMEOUT (100),
        .TO_W    (8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .sel_i     (sel),
        .stb_i     (stb),
        .wdat_i    (wdat),
        .rd_rdy_i  (rd_rdy),
        .rd_vld_o  (rd_vld),
        .rd_dat_o  (rd_dat),
        .cnt_o     (cnt),
        .overflow_o(ovf),
        .pass_o    (pass),
        .fail_o    (fail),
        .timeout_o (tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One-cycle strobe; the capture edge is the only edge consumed.
    task automatic wr1(input logic [7:0] b);
        sel  = 1'b1;
        stb  = 1'b1;
        wdat = b;
        tick();
        stb  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] b);
        wr1(b);
        tick();
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, {23'd0, rd_vld, rd_dat}, {23'd0, 1'b1, exp});
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        chk("reset_outputs", {22'd0, rd_vld, cnt, ovf, pass, fail, tmo}, 32'd0);
        rst = 1'b0;

        // Pass signature with 3-cycle gaps
        do_reset();
        wr1("D"); repeat (3) tick();
        wr1("O"); repeat (3) tick();
        wr1("N"); repeat (3) tick();
        wr1("E");
        chk("pass_not_yet", {31'd0, pass}, 32'd0);
        tick();
        chk("pass_set", {30'd0, pass, fail}, 32'b10);
        chk("pass_cnt", {27'd0, cnt}, 32'd4);
        pop_chk("pop_D", 8'h44);
        pop_chk("pop_O", 8'h4F);
        pop_chk("pop_N", 8'h4E);
        pop_chk("pop_E", 8'h45);
        chk("drained", {31'd0, rd_vld}, 32'd0);

        // Fail signature, then pass is locked out
        do_reset();
        wr("x"); wr("E"); wr("R");
        wr1("R");
        chk("fail_not_yet", {31'd0, fail}, 32'd0);
        tick();
        chk("fail_set", {30'd0, pass, fail}, 32'b01);
        wr("D"); wr("O"); wr("N"); wr("E");
        tick();
        chk("pass_locked_out", {30'd0, pass, fail}, 32'b01);
        chk("fail_cnt", {27'd0, cnt}, 32'd8);

        // Strobe qualification
        do_reset();
        sel = 1'b1; stb = 1'b1; wdat = 8'h41;
        repeat (5) tick();
        stb = 1'b0;
        tick();
        chk("long_strobe_cnt", {27'd0, cnt}, 32'd1);
        chk("long_strobe_dat", {24'd0, rd_dat}, 32'h41);
        do_reset();
        sel = 1'b0; stb = 1'b1;
        repeat (5) tick();
        stb = 1'b0;
        tick();
        chk("unselected_cnt", {27'd0, cnt}, 32'd0);
        stb = 1'b1;
        tick();
        sel = 1'b1;
        repeat (3) tick();
        stb = 1'b0; sel = 1'b0;
        tick();
        chk("late_sel_cnt", {27'd0, cnt}, 32'd0);

        // Overflow: 17 writes into a 16-deep FIFO
        do_reset();
        for (int i = 0; i < 16; i++) wr(8'(i));
        chk("full_cnt", {27'd0, cnt}, 32'd16);
        chk("full_no_ovf", {31'd0, ovf}, 32'd0);
        wr(8'h10);
        chk("ovf_cnt", {27'd0, cnt}, 32'd16);
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        for (int i = 0; i < 16; i++) pop_chk($sformatf("drain_%0d", i), 8'(i));
        chk("ovf_drained", {27'd0, cnt}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);

        // Full with simultaneous pop accepts the push
        do_reset();
        for (int i = 0; i < 16; i++) wr(8'(i));
        rd_rdy = 1'b1; sel = 1'b1; stb = 1'b1; wdat = 8'h55;
        tick();
        rd_rdy = 1'b0; stb = 1'b0;
        chk("fullpop_cnt", {27'd0, cnt}, 32'd16);
        chk("fullpop_no_ovf", {31'd0, ovf}, 32'd0);
        for (int i = 1; i < 16; i++) pop_chk($sformatf("fp_drain_%0d", i), 8'(i));
        pop_chk("fp_drain_new", 8'h55);
        chk("fp_empty", {27'd0, cnt}, 32'd0);

        // Watchdog expiry on the 100th edge after release
        do_reset();
        repeat (99) tick();
        chk("wd_not_yet", {31'd0, tmo}, 32'd0);
        tick();
        chk("wd_expired", {31'd0, tmo}, 32'd1);

        // Pass at cycle ~50 prevents the watchdog
        do_reset();
        repeat (49) tick();
        wr("D"); wr("O"); wr("N"); wr("E");
        repeat (100) tick();
        chk("wd_blocked", {30'd0, pass, tmo}, 32'b10);

        // Reset mid-run
        do_reset();
        wr("a"); wr("D"); wr("O"); wr("N"); wr("E");
        chk("pre_rst_state", {26'd0, cnt, pass}, {26'd0, 5'd5, 1'b1});
        rst = 1'b1;
        #1;
        chk("async_rst_clear", {22'd0, rd_vld, cnt, ovf, pass, fail, tmo}, 32'd0);
        tick();
        rst = 1'b0;
        wr("E"); wr("R");
        wr1("R");
        tick();
        chk("post_rst_fail", {26'd0, cnt, fail}, {26'd0, 5'd3, 1'b1});
        chk("post_rst_pass", {31'd0, pass}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
